// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequencer family.
//   ctrl_state_t : sequencer FSM states
//   DEF_W        : default LFSR state width
//   DEF_CNT_W    : default period/step counter width
//   RES_*        : one-hot result-flag encoding {timeout, lockout, repeat_found}
package lfsr_pkg;

  localparam int unsigned DEF_W     = 64;
  localparam int unsigned DEF_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

  localparam logic [2:0] RES_NONE    = 3'b000;
  localparam logic [2:0] RES_REPEAT  = 3'b001;
  localparam logic [2:0] RES_LOCKOUT = 3'b010;
  localparam logic [2:0] RES_TIMEOUT = 3'b100;

endpackage

// File: rtl/lfsr_step_cnt.sv
// Step counter for the LFSR sequencer.
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   clr      : synchronous clear (wins over en)
//   en       : count one step
//   cnt      : current step count
//   nonzero  : cnt != 0
//   at_limit : cnt == LIMIT
module lfsr_step_cnt
  import lfsr_pkg::*;
#(
  parameter int unsigned      CNT_W = DEF_CNT_W,
  parameter logic [CNT_W-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero,
  output logic             at_limit
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign nonzero  = (cnt != '0);
  assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for an external LFSR: loads a seed, steps the LFSR once per
// clock and reports the repeat period, an all-zero lock-out, or a timeout.
//   clk, reset    : clock (rising edge), asynchronous active-low reset
//   start, abort  : run request (sampled in IDLE), synchronous cancel
//   seed          : starting state, latched when start is accepted
//   lfsr_state    : current state of the external LFSR
//   lfsr_load     : one-cycle load strobe, lfsr_en : shift enable
//   lfsr_seed     : latched seed driven to the LFSR
//   busy, done    : run in progress, one-cycle completion pulse
//   period        : steps until the state returned to the seed
//   repeat_found, lockout, timeout : result flags (exactly one after done)
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned      W         = DEF_W,
  parameter int unsigned      CNT_W     = DEF_CNT_W,
  parameter logic [CNT_W-1:0] MAX_STEPS = CNT_W'(64'hFFFF_FFFF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [W-1:0]     seed,
  input  logic [W-1:0]     lfsr_state,
  output logic             lfsr_load,
  output logic             lfsr_en,
  output logic [W-1:0]     lfsr_seed,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic             repeat_found,
  output logic             lockout,
  output logic             timeout
);

  ctrl_state_t      state;
  ctrl_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_nz;
  logic             cnt_lim;
  logic             match;
  logic             zero;
  logic [2:0]       res;

  // cnt == 0 is the cycle the freshly loaded seed is visible, so it must not
  // count as a repeat.
  assign zero  = (lfsr_state == '0);
  assign match = cnt_nz && (lfsr_state == lfsr_seed);

  // The counter sits at zero everywhere except RUN and advances exactly when
  // the LFSR shifts, so cnt always equals the number of steps taken.
  lfsr_step_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (MAX_STEPS)
  ) u_step_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (state != RUN),
    .en       (lfsr_en),
    .cnt      (cnt),
    .nonzero  (cnt_nz),
    .at_limit (cnt_lim)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (seed == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        lfsr_load = 1'b1;
        busy      = 1'b1;
        state_nxt = abort ? IDLE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (zero || match || cnt_lim) begin
          state_nxt = DONE;
        end else begin
          lfsr_en = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Results hold from the previous run until a new start is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_seed <= '0;
      period    <= '0;
      res       <= RES_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            period <= '0;
            if (seed == '0) begin
              res <= RES_LOCKOUT;
            end else begin
              lfsr_seed <= seed;
              res       <= RES_NONE;
            end
          end
        end
        RUN: begin
          if (!abort) begin
            if (zero) begin
              res    <= RES_LOCKOUT;
              period <= cnt;
            end else if (match) begin
              res    <= RES_REPEAT;
              period <= cnt;
            end else if (cnt_lim) begin
              res    <= RES_TIMEOUT;
              period <= MAX_STEPS;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign repeat_found = |(res & RES_REPEAT);
  assign lockout      = |(res & RES_LOCKOUT);
  assign timeout      = |(res & RES_TIMEOUT);

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: two 4-bit instances (step limit 200 and 10), each
// driving a x^4+x^3+1 LFSR, with a scoreboard of expected done results.
module tb_lfsr_seq_ctrl;

  localparam int W     = 4;
  localparam int CNT_W = 8;
  localparam int LIM_A = 200;
  localparam int LIM_B = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
  logic [W-1:0]     seed = '0;
  logic [W-1:0]     st_a, st_b, lseed_a, lseed_b;
  logic             load_a, en_a, busy_a, done_a, rep_a, lock_a, to_a;
  logic             load_b, en_b, busy_b, done_b, rep_b, lock_b, to_b;
  logic [CNT_W-1:0] period_a, period_b;

  lfsr_seq_ctrl #(.W(W), .CNT_W(CNT_W), .MAX_STEPS(8'(LIM_A))) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort), .seed(seed),
    .lfsr_state(st_a), .lfsr_load(load_a), .lfsr_en(en_a), .lfsr_seed(lseed_a),
    .busy(busy_a), .done(done_a), .period(period_a), .repeat_found(rep_a),
    .lockout(lock_a), .timeout(to_a));

  lfsr_seq_ctrl #(.W(W), .CNT_W(CNT_W), .MAX_STEPS(8'(LIM_B))) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort), .seed(seed),
    .lfsr_state(st_b), .lfsr_load(load_b), .lfsr_en(en_b), .lfsr_seed(lseed_b),
    .busy(busy_b), .done(done_b), .period(period_b), .repeat_found(rep_b),
    .lockout(lock_b), .timeout(to_b));

  function automatic logic [3:0] lfsr_step(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  // External LFSR instances.
  always @(posedge clk or negedge reset) begin
    if (!reset) st_a <= '0;
    else if (load_a) st_a <= lseed_a;
    else if (en_a) st_a <= lfsr_step(st_a);
  end
  always @(posedge clk or negedge reset) begin
    if (!reset) st_b <= '0;
    else if (load_b) st_b <= lseed_b;
    else if (en_b) st_b <= lfsr_step(st_b);
  end

  // flags = {timeout, lockout, repeat_found}; when = cycle of the done pulse
  typedef struct {
    int         period;
    logic [2:0] flags;
    int         when;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Walk the LFSR sequence from the seed and report what ends the run first.
  function automatic exp_t model(input logic [3:0] sd, input int limit, input int c0);
    exp_t       e;
    logic [3:0] s;
    e.period = 0; e.flags = 3'b010; e.when = c0 + 1;
    if (sd == 4'd0) return e;
    s = sd;
    for (int c = 0; c <= limit; c++) begin
      if (s == 4'd0) begin
        e.period = c; e.flags = 3'b010; e.when = c0 + 3 + c; return e;
      end
      if (c != 0 && s == sd) begin
        e.period = c; e.flags = 3'b001; e.when = c0 + 3 + c; return e;
      end
      if (c == limit) begin
        e.period = limit; e.flags = 3'b100; e.when = c0 + 3 + c; return e;
      end
      s = lfsr_step(s);
    end
    return e;
  endfunction

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: done pulse with no run outstanding (cycle %0d)", nm, cyc);
  endtask

  task automatic cmp_done(input string nm, input int per, input logic [2:0] fl, input exp_t e);
    chk({nm, "_period"}, per, e.period);
    chk({nm, "_flags"}, fl, e.flags);
    chk({nm, "_done_cycle"}, cyc, e.when);
  endtask

  // Monitors: pop and compare whenever a done pulse is presented.
  exp_t ea, eb;
  always @(negedge clk) begin
    if (reset && done_a) begin
      if (qa.size() == 0) unexpected("a_done");
      else begin
        ea = qa.pop_front();
        cmp_done("a", int'(period_a), {to_a, lock_a, rep_a}, ea);
      end
    end
  end
  always @(negedge clk) begin
    if (reset && done_b) begin
      if (qb.size() == 0) unexpected("b_done");
      else begin
        eb = qb.pop_front();
        cmp_done("b", int'(period_b), {to_b, lock_b, rep_b}, eb);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic launch(input logic [3:0] sd, output int c0);
    seed = sd;
    start_a = 1'b1;
    start_b = 1'b1;
    c0 = cyc;
    qa.push_back(model(sd, LIM_A, c0));
    qb.push_back(model(sd, LIM_B, c0));
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic pulse_start();
    start_a = 1'b1;
    start_b = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic do_abort(input int at);
    wait_to(at);
    abort = 1'b1;
    qa.delete();
    qb.delete();
    tick();
    abort = 1'b0;
    chk("abort_busy_a", busy_a, 0);
    chk("abort_busy_b", busy_b, 0);
    chk("abort_en_a", en_a, 0);
  endtask

  task automatic settle(input int c0);
    wait_to(c0 + 21);
    chk("a_pending", qa.size(), 0);
    chk("b_pending", qb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int kmax;
    logic [3:0] sd;

    // Reset state
    tick(); tick();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_load", load_a, 0);
    chk("rst_en", en_a, 0);
    chk("rst_period", period_a, 0);
    chk("rst_flags", {to_a, lock_a, rep_a}, 0);
    chk("rst_lseed", lseed_a, 0);
    reset = 1'b1;
    tick();

    // Seed 1 with ignored re-starts at cycles 5 and 18
    launch(4'h1, c0);
    chk("load_c1", load_a, 1);
    chk("en_c1", en_a, 0);
    chk("lseed_c1", lseed_a, 1);
    tick();
    chk("load_c2", load_a, 0);
    chk("en_c2", en_a, 1);
    wait_to(c0 + 5);
    pulse_start();
    wait_to(c0 + 11);
    chk("b_en_c11", en_b, 1);
    tick();
    chk("b_en_c12", en_b, 0);
    chk("b_busy_c12", busy_b, 1);
    wait_to(c0 + 18);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_busy_c19", busy_a, 0);
    tick();
    chk("a_busy_c20", busy_a, 0);
    settle(c0);
    chk("a_hold_period", period_a, 15);
    chk("a_hold_repeat", rep_a, 1);

    // Zero seed: lock-out without a load
    launch(4'h0, c0);
    chk("z_load_c1", load_a, 0);
    chk("z_busy_c1", busy_a, 0);
    settle(c0);

    // Abort in cycle 7, then a fresh run from seed 8
    launch(4'h1, c0);
    do_abort(c0 + 7);
    settle(c0);
    launch(4'h8, c0);
    settle(c0);

    // Reset mid-run in cycle 6
    launch(4'h1, c0);
    wait_to(c0 + 6);
    #1 reset = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    chk("mr_busy", busy_a, 0);
    chk("mr_en", en_a, 0);
    chk("mr_load", load_a, 0);
    chk("mr_period", period_a, 0);
    chk("mr_flags", {to_a, lock_a, rep_a}, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    launch(4'h1, c0);
    settle(c0);

    // Reset while idle clears held results
    chk("idle_period_pre", period_b, 10);
    #1 reset = 1'b0;
    #1;
    chk("idle_rst_period", period_b, 0);
    chk("idle_rst_timeout", to_b, 0);
    chk("idle_rst_lseed", lseed_a, 0);
    tick();
    reset = 1'b1;
    tick();

    // Randomized runs
    for (int i = 0; i < 30; i++) begin
      sd = 4'($urandom_range(0, 15));
      launch(sd, c0);
      if (sd != 4'd0) begin
        kmax = qb[0].when - c0 - 1;
        if ($urandom_range(0, 3) == 0) begin
          do_abort(c0 + int'($urandom_range(1, kmax)));
        end else if ($urandom_range(0, 1) == 0) begin
          wait_to(c0 + int'($urandom_range(2, kmax)));
          pulse_start();
        end
      end
      settle(c0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
- Sequencer for the LFSR datapath (lfsr16 family).
- On start, it loads a seed into an external LFSR, steps it one shift per clock, and watches the LFSR state.
- It reports the repeat period, a lock-out seed/state, or a step-limit timeout.
- It is the hardware replacement for bench-side period checking and sits between the top-level control and the LFSR instance.

Parameters:
W, 64, LFSR state width in bits
CNT_W, 32, period/step counter width
MAX_STEPS, 32'hFFFF_FFFF, step limit before timeout; must be < 2^CNT_W

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request a run; sampled only in IDLE
abort  in  1  synchronous cancel; returns to IDLE with no done pulse
seed  in  W  starting state, latched when start is accepted
lfsr_state  in  W  current LFSR output (shift_seed)
lfsr_load  out  1  one-cycle load strobe to the LFSR
lfsr_en  out  1  shift enable to the LFSR
lfsr_seed  out  W  latched seed driven to the LFSR
busy  out  1  high in LOAD and RUN
done  out  1  one-cycle completion pulse
period  out  CNT_W  steps until lfsr_state equalled the seed again
repeat_found  out  1  period valid
lockout  out  1  all-zero seed or all-zero state seen
timeout  out  1  MAX_STEPS reached without a repeat

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - All outputs and registers go to 0, including lfsr_seed, period and the flags.
  - Reset mid-run abandons the run; there is no done pulse.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 and seed!=0: latch seed, clear the flags and counter, go to LOAD.
  - start=1 and seed==0: set lockout=1, period=0, go to DONE with no load.
  - Flags and period hold from the previous run until start is accepted.
- LOAD (1 cycle): lfsr_load=1, lfsr_en=0, busy=1; go to RUN with cnt=0.
- RUN:
  - In the cycle where cnt=c, lfsr_state is the seed advanced c steps.
  - lfsr_en is combinational: lfsr_en = RUN & ~match & ~zero & ~limit & ~abort.
  - match = (cnt!=0) & (lfsr_state==lfsr_seed). On match: period<=cnt, repeat_found<=1, go to DONE.
  - zero = (lfsr_state==0). On zero: lockout<=1, period<=cnt, go to DONE.
  - limit = (cnt==MAX_STEPS) with no match. On limit: timeout<=1, period<=MAX_STEPS, go to DONE.
  - Otherwise cnt<=cnt+1; the counter never wraps because limit fires first.
  - Priority when several hold in the same cycle: abort > zero > match > limit.
- DONE (1 cycle): done=1, busy=0; go to IDLE. A start in DONE is ignored.
- start while busy is ignored; there is no queueing.
- abort in LOAD or RUN: go to IDLE next cycle, lfsr_en=0, flags stay cleared, no done pulse.
- Exactly one of repeat_found, lockout, timeout is high after done.
- Latency: start in cycle 0 gives LOAD in cycle 1, RUN from cycle 2, and done in cycle 3+P for period P.

Decomposition:
- Shared package lfsr_pkg holds:
  - enum ctrl_state_t {IDLE, LOAD, RUN, DONE};
  - default W / CNT_W constants;
  - result-flag encoding constants.
- One sub-module, lfsr_step_cnt:
  - CNT_W counter with clear/enable;
  - cnt!=0 and cnt==MAX_STEPS compares.
- The LFSR itself stays an external instance.

Test Plan:
- W=4 maximal LFSR (x^4+x^3+1), seed 4'h1, start pulse at cycle 0 -> lfsr_load high in cycle 1; done in cycle 18; period=15; repeat_found=1; lockout=0; timeout=0.
- seed 0, start -> no lfsr_load; done in cycle 1; lockout=1; period=0; repeat_found=0.
- W=4, MAX_STEPS=10, seed 4'h1 -> done in cycle 13; timeout=1; period=10; lfsr_en deasserted in cycle 12.
- Run with seed 4'h1, start re-asserted in cycles 5 and 18 -> ignored; only one done pulse; period=15.
- Abort in cycle 7 of a run -> IDLE in cycle 8; no done; busy=0; new start with seed 4'h8 -> period=15.
- reset low in cycle 6 of a run -> busy, lfsr_en, lfsr_load, flags and period all 0 immediately; after reset release a normal run completes with period=15.
